// File: rtl/traffic_lamp_sequencer.sv
// Lamp sequencer behind the 4-way phase controller: converts per-lane RED/GREEN requests into
// red/amber/green lamp drive with amber and all-red clearance, and latches a flashing-amber fault.
module traffic_lamp_sequencer #(
    parameter int AMBER_TIME  = 3,
    parameter int ALLRED_TIME = 2,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] r1,
    input  logic [1:0] r2,
    input  logic [1:0] r3,
    input  logic [1:0] r4,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic [2:0] lamp3,
    output logic [2:0] lamp4,
    output logic [1:0] active_lane,
    output logic [2:0] phase,
    output logic       fault
);

    localparam int MAX_T01 = (AMBER_TIME > ALLRED_TIME) ? AMBER_TIME : ALLRED_TIME;
    localparam int MAX_T   = (MAX_T01 > FLASH_HALF) ? MAX_T01 : FLASH_HALF;
    localparam int TW      = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_AMBER  = TW'(AMBER_TIME);
    localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_TIME);
    localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_HALF);

    localparam logic [2:0] S_ALLRED = 3'd0;
    localparam logic [2:0] S_GREEN  = 3'd1;
    localparam logic [2:0] S_AMBER  = 3'd2;
    localparam logic [2:0] S_FAULT  = 3'd3;

    localparam logic [2:0] LAMP_RED   = 3'b100;
    localparam logic [2:0] LAMP_AMBER = 3'b010;
    localparam logic [2:0] LAMP_GREEN = 3'b001;
    localparam logic [2:0] LAMP_OFF   = 3'b000;

    logic [2:0]      r_state;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_lane;
    logic            r_fault;
    logic            r_flash;

    logic [2:0]      w_state_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [1:0]      w_lane_nxt;
    logic            w_fault_nxt;
    logic            w_flash_nxt;

    logic [3:0][1:0] w_codes;
    logic [2:0]      w_green_cnt;
    logic            w_bad_code;
    logic [1:0]      w_req_lane;
    logic            w_valid;
    logic            w_conflict;
    logic [3:0][2:0] w_lamps;

    assign w_codes = {r4, r3, r2, r1};

    // Request decode: count GREEN codes, flag any code that is neither RED nor GREEN
    always_comb begin
        w_green_cnt = 3'd0;
        w_bad_code  = 1'b0;
        w_req_lane  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            case (w_codes[i])
                2'b10: w_green_cnt = w_green_cnt;
                2'b01: begin
                    w_green_cnt = w_green_cnt + 3'd1;
                    w_req_lane  = i[1:0];
                end
                default: w_bad_code = 1'b1;
            endcase
        end
        w_conflict = w_bad_code || (w_green_cnt > 3'd1);
        w_valid    = !w_conflict && (w_green_cnt == 3'd1);
    end

    // Next-state logic; FAULT is absorbing and ignores the request inputs
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_lane_nxt  = r_lane;
        w_fault_nxt = r_fault;
        w_flash_nxt = r_flash;
        if (r_state == S_FAULT) begin
            if (r_timer <= T_ONE) begin
                w_flash_nxt = ~r_flash;
                w_timer_nxt = T_FLASH;
            end else begin
                w_timer_nxt = r_timer - T_ONE;
            end
        end else if (w_conflict) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
            w_flash_nxt = 1'b1;
            w_timer_nxt = T_FLASH;
        end else begin
            case (r_state)
                S_ALLRED: begin
                    if (r_timer <= T_ONE) begin
                        if (w_valid) begin
                            w_state_nxt = S_GREEN;
                            w_lane_nxt  = w_req_lane;
                        end else begin
                            w_timer_nxt = T_ONE;
                        end
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                S_GREEN: begin
                    if (!w_valid || (w_req_lane != r_lane)) begin
                        w_state_nxt = S_AMBER;
                        w_timer_nxt = T_AMBER;
                    end else begin
                        w_timer_nxt = r_timer;
                    end
                end
                S_AMBER: begin
                    if (r_timer <= T_ONE) begin
                        w_state_nxt = S_ALLRED;
                        w_timer_nxt = T_ALLRED;
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                default: begin
                    // Unused encodings are treated as a corrupted state and fail safe
                    w_state_nxt = S_FAULT;
                    w_fault_nxt = 1'b1;
                    w_flash_nxt = 1'b1;
                    w_timer_nxt = T_FLASH;
                end
            endcase
        end
    end

    // State, timer, lane, fault and flash registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ALLRED;
            r_timer <= T_ALLRED;
            r_lane  <= 2'd0;
            r_fault <= 1'b0;
            r_flash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_lane  <= w_lane_nxt;
            r_fault <= w_fault_nxt;
            r_flash <= w_flash_nxt;
        end
    end

    // Lamp decode from registered state only
    always_comb begin
        w_lamps = {4{LAMP_RED}};
        case (r_state)
            S_ALLRED: w_lamps = {4{LAMP_RED}};
            S_GREEN:  w_lamps[r_lane] = LAMP_GREEN;
            S_AMBER:  w_lamps[r_lane] = LAMP_AMBER;
            S_FAULT:  w_lamps = r_flash ? {4{LAMP_AMBER}} : {4{LAMP_OFF}};
            default:  w_lamps = {4{LAMP_RED}};
        endcase
    end

    assign lamp1       = w_lamps[0];
    assign lamp2       = w_lamps[1];
    assign lamp3       = w_lamps[2];
    assign lamp4       = w_lamps[3];
    assign active_lane = r_lane;
    assign phase       = r_state;
    assign fault       = r_fault;

endmodule
